sram_arbiter: RTL and testbench

Shares one external 32-bit asynchronous SRAM between the instruction-fetch port and the data-access port of the genshinmips core. Sits between `pc_reg`/`if_id` on the fetch side, `mem` on the data side, and the board SRAM pins. It sequences multi-cycle SRAM read and write strobes, grants one requester at a time, and raises a stall request to `ctrl` while any request is outstanding.

---
 rtl/sram_arbiter.sv | 151 +++++++++++++++
 tb/tb_sram_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous 32-bit SRAM between the fetch and
// data ports of the core. Data wins over fetch. Each access runs through a
// short strobe sequence. Stall is requested while either port is waiting.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | bus quiet, picks the next requester (data first)
// S_RD      | ce/oe asserted for WAIT_CYCLES+1 cycles, sample on last edge
// S_WR_SETUP| address, data and byte enables settle before we_n falls
// S_WR      | we_n low for WAIT_CYCLES+1 cycles
// S_DONE    | strobes released, ready pulse to granted port, turnaround
module sram_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_AW     = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inst_req_i,
  input  logic [31:0]        inst_addr_i,
  output logic [31:0]        inst_rdata_o,
  output logic               inst_ready_o,
  input  logic               data_req_i,
  input  logic               data_we_i,
  input  logic [3:0]         data_sel_i,
  input  logic [31:0]        data_addr_i,
  input  logic [31:0]        data_wdata_i,
  output logic [31:0]        data_rdata_o,
  output logic               data_ready_o,
  output logic               stallreq_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [31:0]        sram_wdata_o,
  output logic               sram_dout_en_o,
  input  logic [31:0]        sram_rdata_i,
  output logic               sram_ce_n_o,
  output logic               sram_oe_n_o,
  output logic               sram_we_n_o,
  output logic [3:0]         sram_be_n_o
);

  localparam int CW = $clog2(WAIT_CYCLES + 2);
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR,
    S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          grant_data;

  // The SRAM is word addressed, so byte-offset and high address bits are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{inst_addr_i[1:0], inst_addr_i[31:SRAM_AW+2],
                              data_addr_i[1:0], data_addr_i[31:SRAM_AW+2]};

  // Stall while any request has not yet seen its ready pulse.
  assign stallreq_o = (inst_req_i & ~inst_ready_o) | (data_req_i & ~data_ready_o);

  // Access sequencer: strobes are registered and set on the transition into each state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      grant_data     <= 1'b0;
      sram_ce_n_o    <= 1'b1;
      sram_oe_n_o    <= 1'b1;
      sram_we_n_o    <= 1'b1;
      sram_be_n_o    <= 4'b1111;
      sram_dout_en_o <= 1'b0;
      sram_addr_o    <= '0;
      sram_wdata_o   <= '0;
      inst_ready_o   <= 1'b0;
      data_ready_o   <= 1'b0;
      inst_rdata_o   <= '0;
      data_rdata_o   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (data_req_i) begin
            grant_data   <= 1'b1;
            sram_addr_o  <= data_addr_i[SRAM_AW+1:2];
            sram_wdata_o <= data_wdata_i;
            sram_ce_n_o  <= 1'b0;
            cnt          <= CNT_INIT;
            if (data_we_i) begin
              sram_be_n_o    <= ~data_sel_i;
              sram_dout_en_o <= 1'b1;
              state          <= S_WR_SETUP;
            end else begin
              sram_oe_n_o <= 1'b0;
              sram_be_n_o <= 4'b0000;
              state       <= S_RD;
            end
          end else if (inst_req_i) begin
            grant_data  <= 1'b0;
            sram_addr_o <= inst_addr_i[SRAM_AW+1:2];
            sram_ce_n_o <= 1'b0;
            sram_oe_n_o <= 1'b0;
            sram_be_n_o <= 4'b0000;
            cnt         <= CNT_INIT;
            state       <= S_RD;
          end
        end
        S_RD: begin
          if (cnt == '0) begin
            if (grant_data) begin
              data_rdata_o <= sram_rdata_i;
              data_ready_o <= 1'b1;
            end else begin
              inst_rdata_o <= sram_rdata_i;
              inst_ready_o <= 1'b1;
            end
            sram_ce_n_o <= 1'b1;
            sram_oe_n_o <= 1'b1;
            sram_be_n_o <= 4'b1111;
            state       <= S_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_WR_SETUP: begin
          sram_we_n_o <= 1'b0;
          state       <= S_WR;
        end
        S_WR: begin
          if (cnt == '0) begin
            sram_ce_n_o    <= 1'b1;
            sram_we_n_o    <= 1'b1;
            sram_be_n_o    <= 4'b1111;
            sram_dout_en_o <= 1'b0;
            data_ready_o   <= 1'b1;
            state          <= S_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DONE: begin
          inst_ready_o <= 1'b0;
          data_ready_o <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: one instance with WAIT_CYCLES=1 for most scenarios,
// one with WAIT_CYCLES=0 for back-to-back fetch spacing.
module tb_sram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        inst_req, data_req, data_we;
  logic [3:0]  data_sel;
  logic [31:0] inst_addr, data_addr, data_wdata, inst_rdata, data_rdata;
  logic        inst_ready, data_ready, stallreq;
  logic [19:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic        dout_en, ce_n, oe_n, we_n;
  logic [3:0]  be_n;

  logic        inst_req0;
  logic [31:0] inst_addr0, inst_rdata0, data_rdata0;
  logic        inst_ready0, data_ready0, stallreq0;
  logic [19:0] sram_addr0;
  logic [31:0] sram_wdata0, sram_rdata0;
  logic        dout_en0, ce_n0, oe_n0, we_n0;
  logic [3:0]  be_n0;

  sram_arbiter #(.WAIT_CYCLES(1), .SRAM_AW(20)) dut (
    .clk(clk), .rst(rst),
    .inst_req_i(inst_req), .inst_addr_i(inst_addr), .inst_rdata_o(inst_rdata),
    .inst_ready_o(inst_ready),
    .data_req_i(data_req), .data_we_i(data_we), .data_sel_i(data_sel),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_rdata_o(data_rdata),
    .data_ready_o(data_ready), .stallreq_o(stallreq),
    .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_dout_en_o(dout_en),
    .sram_rdata_i(sram_rdata), .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n),
    .sram_we_n_o(we_n), .sram_be_n_o(be_n)
  );

  sram_arbiter #(.WAIT_CYCLES(0), .SRAM_AW(20)) dut0 (
    .clk(clk), .rst(rst),
    .inst_req_i(inst_req0), .inst_addr_i(inst_addr0), .inst_rdata_o(inst_rdata0),
    .inst_ready_o(inst_ready0),
    .data_req_i(1'b0), .data_we_i(1'b0), .data_sel_i(4'b0000),
    .data_addr_i(32'h0), .data_wdata_i(32'h0), .data_rdata_o(data_rdata0),
    .data_ready_o(data_ready0), .stallreq_o(stallreq0),
    .sram_addr_o(sram_addr0), .sram_wdata_o(sram_wdata0), .sram_dout_en_o(dout_en0),
    .sram_rdata_i(sram_rdata0), .sram_ce_n_o(ce_n0), .sram_oe_n_o(oe_n0),
    .sram_we_n_o(we_n0), .sram_be_n_o(be_n0)
  );

  // SRAM models (word addressed, low 10 address bits), plus a backdoor preload port
  logic [31:0] mem1 [0:1023];
  logic [31:0] mem0 [0:1023];
  logic        pl_en = 1'b0, pl_which = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) begin
      if (pl_which) mem1[pl_addr] <= pl_data;
      else          mem0[pl_addr] <= pl_data;
    end
    if (!ce_n && !we_n && dout_en)
      for (int i = 0; i < 4; i++)
        if (!be_n[i]) mem1[sram_addr[9:0]][8*i +: 8] <= sram_wdata[8*i +: 8];
  end

  assign sram_rdata  = (!ce_n  && !oe_n ) ? mem1[sram_addr[9:0]]  : 32'hDEAD_BEEF;
  assign sram_rdata0 = (!ce_n0 && !oe_n0) ? mem0[sram_addr0[9:0]] : 32'hDEAD_BEEF;

  // Protocol watch: we_n must never be low in a cycle where the address changed
  int          prot_err = 0;
  int          cyc = 0;
  logic [19:0] prev_addr = '0;
  always @(negedge clk) begin
    cyc++;
    if (!we_n && sram_addr != prev_addr) prot_err++;
    if (!we_n && !dout_en) prot_err++;
    prev_addr = sram_addr;
  end

  int n_cmp = 0, n_err = 0;

  // results of the most recent run1() transaction
  int r_lat, r_oe, r_we, r_setup, r_viol, r_addr_bad, r_be_bad;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    logic [31:0] mask;
    mask = 32'h0;
    for (int i = 0; i < 4; i++) if (sel[i]) mask = mask | (32'hFF << (8*i));
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  task automatic preload(input logic which, input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_which = which; pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // One transaction on the WAIT_CYCLES=1 instance; gathers observations only
  task automatic run1(input logic is_data, input logic we, input logic [3:0] sel,
                      input logic [31:0] addr, input logic [31:0] wdata);
    logic [3:0] exp_be;
    exp_be = (is_data && we) ? ~sel : 4'b0000;
    r_lat = -1; r_oe = 0; r_we = 0; r_setup = 0; r_viol = 0; r_addr_bad = 0; r_be_bad = 0;
    @(negedge clk);
    if (is_data) begin
      data_req = 1'b1; data_we = we; data_sel = sel; data_addr = addr; data_wdata = wdata;
    end else begin
      inst_req = 1'b1; inst_addr = addr;
    end
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (!oe_n) r_oe++;
      if (!we_n) r_we++;
      if (!ce_n && we_n && oe_n) r_setup++;
      if (!ce_n && sram_addr != addr[21:2]) r_addr_bad++;
      if (!ce_n && be_n != exp_be) r_be_bad++;
      if ((is_data ? inst_ready : data_ready) == 1'b1) r_viol++;
      if ((is_data ? data_ready : inst_ready) == 1'b1) begin
        r_lat = n;
        break;
      end
      if (!stallreq) r_viol++;
    end
    data_req = 1'b0; inst_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #23;
    n_cmp++;
    if ({ce_n, oe_n, we_n, be_n, dout_en} !== 8'b1111_1110) begin
      n_err++; $display("FAIL reset_strobes got %b want 11111110", {ce_n, oe_n, we_n, be_n, dout_en});
    end
    n_cmp++;
    if (sram_addr !== 20'h0 || sram_wdata !== 32'h0) begin
      n_err++; $display("FAIL reset_bus got addr=%h wdata=%h want 0/0", sram_addr, sram_wdata);
    end
    n_cmp++;
    if ({inst_ready, data_ready, stallreq} !== 3'b000) begin
      n_err++; $display("FAIL reset_ready got %b want 000", {inst_ready, data_ready, stallreq});
    end
    n_cmp++;
    if (inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin
      n_err++; $display("FAIL reset_rdata got %h/%h want 0/0", inst_rdata, data_rdata);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fetch_read();
    preload(1'b1, 10'h100, 32'h2401_0005);
    run1(1'b0, 1'b0, 4'b0000, 32'h0000_0400, 32'h0);
    n_cmp++;
    if (r_lat != 3) begin n_err++; $display("FAIL fetch_latency got %0d want 3", r_lat); end
    n_cmp++;
    if (r_oe != 2 || r_addr_bad != 0 || r_be_bad != 0) begin
      n_err++; $display("FAIL fetch_strobes got oe_cycles=%0d addr_bad=%0d be_bad=%0d want 2/0/0",
                        r_oe, r_addr_bad, r_be_bad);
    end
    n_cmp++;
    if (r_viol != 0) begin n_err++; $display("FAIL fetch_stall got violations=%0d want 0", r_viol); end
    n_cmp++;
    if (inst_rdata !== 32'h2401_0005) begin
      n_err++; $display("FAIL fetch_rdata got %h want 24010005", inst_rdata);
    end
  endtask

  task automatic test_byte_write();
    preload(1'b1, 10'h002, 32'h1122_3344);
    run1(1'b1, 1'b1, 4'b0011, 32'h0000_0008, 32'hAABB_CCDD);
    n_cmp++;
    if (r_lat != 4) begin n_err++; $display("FAIL write_latency got %0d want 4", r_lat); end
    n_cmp++;
    if (r_we != 2 || r_setup != 1 || r_oe != 0) begin
      n_err++; $display("FAIL write_strobes got we=%0d setup=%0d oe=%0d want 2/1/0", r_we, r_setup, r_oe);
    end
    n_cmp++;
    if (r_be_bad != 0 || r_addr_bad != 0 || r_viol != 0) begin
      n_err++; $display("FAIL write_be got be_bad=%0d addr_bad=%0d viol=%0d want 0/0/0",
                        r_be_bad, r_addr_bad, r_viol);
    end
    n_cmp++;
    if (mem1[2] !== merge(32'h1122_3344, 32'hAABB_CCDD, 4'b0011)) begin
      n_err++; $display("FAIL write_mem got %h want %h", mem1[2], merge(32'h1122_3344, 32'hAABB_CCDD, 4'b0011));
    end
    n_cmp++;
    if (data_rdata !== 32'h0) begin n_err++; $display("FAIL write_rdata got %h want 0", data_rdata); end
  endtask

  task automatic test_simultaneous();
    int d_at, i_at, gap;
    logic [31:0] va, vb;
    va = $urandom; vb = $urandom;
    preload(1'b1, 10'h010, va);
    preload(1'b1, 10'h020, vb);
    @(negedge clk);
    d_at = -1; i_at = -1; gap = 0;
    data_req = 1'b1; data_we = 1'b0; data_sel = 4'b1111; data_addr = 32'h40;
    inst_req = 1'b1; inst_addr = 32'h80;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (!stallreq && !inst_ready) gap++;
      if (data_ready) begin d_at = n; data_req = 1'b0; end
      if (inst_ready) begin i_at = n; inst_req = 1'b0; break; end
    end
    data_req = 1'b0; inst_req = 1'b0;
    n_cmp++;
    if (d_at != 3 || i_at != 7) begin
      n_err++; $display("FAIL simul_order got data@%0d inst@%0d want 3/7", d_at, i_at);
    end
    n_cmp++;
    if (gap != 0) begin n_err++; $display("FAIL simul_stall got gaps=%0d want 0", gap); end
    n_cmp++;
    if (data_rdata !== va || inst_rdata !== vb) begin
      n_err++; $display("FAIL simul_rdata got %h/%h want %h/%h", data_rdata, inst_rdata, va, vb);
    end
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      n_cmp++;
      if ({ce_n, oe_n, we_n, be_n, dout_en, stallreq} !== 9'b1111_1110_0 ||
          {ce_n0, oe_n0, we_n0, be_n0, dout_en0, stallreq0} !== 9'b1111_1110_0) begin
        n_err++; $display("FAIL idle_bus got %b %b want 111111100", {ce_n, oe_n, we_n, be_n, dout_en, stallreq},
                          {ce_n0, oe_n0, we_n0, be_n0, dout_en0, stallreq0});
      end
    end
  endtask

  task automatic test_back_to_back();
    int rd_at [3];
    int oe_at [3];
    int lat0;
    logic [31:0] v [3];
    lat0 = -1;
    for (int k = 0; k < 3; k++) begin
      v[k] = $urandom;
      preload(1'b0, 10'(k), v[k]);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      rd_at[k] = -1; oe_at[k] = -1;
      inst_req0 = 1'b1; inst_addr0 = 32'(k * 4);
      for (int n = 1; n <= 10; n++) begin
        @(negedge clk);
        if (!oe_n0 && oe_at[k] < 0) oe_at[k] = cyc;
        if (inst_ready0) begin
          rd_at[k] = cyc;
          if (k == 0) lat0 = n;
          break;
        end
      end
      inst_req0 = 1'b0;
      n_cmp++;
      if (rd_at[k] < 0 || rd_at[k] - oe_at[k] != 1) begin
        n_err++; $display("FAIL b2b_latency[%0d] got ready@%0d oe@%0d want ready one cycle after the read cycle",
                          k, rd_at[k], oe_at[k]);
      end
      n_cmp++;
      if (inst_rdata0 !== v[k]) begin
        n_err++; $display("FAIL b2b_rdata[%0d] got %h want %h", k, inst_rdata0, v[k]);
      end
      if (k > 0) begin
        n_cmp++;
        if (rd_at[k] - rd_at[k-1] != 3) begin
          n_err++; $display("FAIL b2b_spacing[%0d] got %0d want 3", k, rd_at[k] - rd_at[k-1]);
        end
      end
      if (k < 2) inst_req0 = 1'b1;
      inst_req0 = 1'b0;
    end
    n_cmp++;
    if (lat0 != 2) begin n_err++; $display("FAIL b2b_first got %0d want 2", lat0); end
    n_cmp++;
    if (data_ready0 !== 1'b0 || data_rdata0 !== 32'h0) begin
      n_err++; $display("FAIL b2b_dataport got %b/%h want 0/0", data_ready0, data_rdata0);
    end
  endtask

  task automatic test_reset_mid_access();
    int found, ready_seen, lat;
    preload(1'b1, 10'h005, 32'h5555_5555);
    @(negedge clk);
    found = 0; ready_seen = 0; lat = -1;
    data_req = 1'b1; data_we = 1'b1; data_sel = 4'b1111; data_addr = 32'h14; data_wdata = 32'h1234_5678;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (data_ready) ready_seen++;
      if (!we_n) begin found = 1; break; end
    end
    n_cmp++;
    if (found != 1) begin n_err++; $display("FAIL rstmid_reach_wr got %0d want 1", found); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({we_n, dout_en, ce_n} !== 3'b101) begin
      n_err++; $display("FAIL rstmid_abort got we/dout/ce=%b want 101", {we_n, dout_en, ce_n});
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (data_ready) ready_seen++;
    end
    n_cmp++;
    if (ready_seen != 0) begin n_err++; $display("FAIL rstmid_noready got %0d want 0", ready_seen); end
    rst = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (data_ready) begin lat = n; break; end
    end
    data_req = 1'b0;
    n_cmp++;
    if (lat != 4) begin n_err++; $display("FAIL rstmid_regrant got %0d want 4", lat); end
    n_cmp++;
    if (mem1[5] !== 32'h1234_5678) begin
      n_err++; $display("FAIL rstmid_mem got %h want 12345678", mem1[5]);
    end
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [16];
    logic [31:0] exp_inst, exp_data, wd;
    logic        is_data, we;
    logic [3:0]  sel, idx;
    exp_inst = 32'h0; exp_data = 32'h0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      preload(1'b1, 10'h200 + 10'(i), ref_mem[i]);
    end
    for (int t = 0; t < 40; t++) begin
      is_data = 1'($urandom_range(0, 1));
      we      = is_data & 1'($urandom_range(0, 1));
      idx     = 4'($urandom_range(0, 15));
      sel     = 4'($urandom_range(1, 15));
      wd      = $urandom;
      run1(is_data, we, sel, 32'h800 + 32'(idx) * 4, wd);
      if (we) ref_mem[idx] = merge(ref_mem[idx], wd, sel);
      else if (is_data) exp_data = ref_mem[idx];
      else exp_inst = ref_mem[idx];
      n_cmp++;
      if (r_lat != (we ? 4 : 3) || r_we != (we ? 2 : 0) || r_oe != (we ? 0 : 2)) begin
        n_err++; $display("FAIL rand_timing[%0d] got lat=%0d we=%0d oe=%0d want %0d/%0d/%0d", t, r_lat,
                          r_we, r_oe, we ? 4 : 3, we ? 2 : 0, we ? 0 : 2);
      end
      n_cmp++;
      if (r_viol != 0 || r_addr_bad != 0 || r_be_bad != 0) begin
        n_err++; $display("FAIL rand_bus[%0d] got viol=%0d addr_bad=%0d be_bad=%0d want 0/0/0", t,
                          r_viol, r_addr_bad, r_be_bad);
      end
      n_cmp++;
      if (inst_rdata !== exp_inst || data_rdata !== exp_data) begin
        n_err++; $display("FAIL rand_rdata[%0d] got %h/%h want %h/%h", t, inst_rdata, data_rdata,
                          exp_inst, exp_data);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (mem1[10'h200 + 10'(i)] !== ref_mem[i]) begin
        n_err++; $display("FAIL rand_mem[%0d] got %h want %h", i, mem1[10'h200 + 10'(i)], ref_mem[i]);
      end
    end
    n_cmp++;
    if (prot_err != 0) begin n_err++; $display("FAIL we_addr_protocol got %0d want 0", prot_err); end
  endtask

  initial begin
    inst_req = 1'b0; data_req = 1'b0; data_we = 1'b0; data_sel = 4'b0000;
    inst_addr = '0; data_addr = '0; data_wdata = '0;
    inst_req0 = 1'b0; inst_addr0 = '0;
    test_reset();
    test_fetch_read();
    test_byte_write();
    test_simultaneous();
    test_idle();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got no finish want finish before 1ms");
    $fatal(1, "timeout");
  end

endmodule
